// File: rtl/mem_arbiter.sv
// Memory arbiter that serves I-cache fills, D-cache fills and D-cache dirty-line writebacks over one memory port.
// Define MEM_ARB_RR_EN to switch D-side/I-side arbitration from fixed priority to round-robin.
module mem_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [13:0] i_addr,
    input  logic        d_req,
    input  logic [13:0] d_addr,
    input  logic        d_wb_req,
    input  logic [13:0] d_wb_addr,
    input  logic [63:0] d_wb_data,
    output logic        i_vld,
    output logic        d_vld,
    output logic        d_wb_done,
    output logic [63:0] rd_line,
    output logic        mem_re,
    output logic        mem_we,
    output logic [13:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata,
    input  logic        mem_rdy,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB     = 3'd1,
        D_FILL = 3'd2,
        I_FILL = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic        re_s;
    logic        we_s;
    logic        i_vld_s;
    logic        d_vld_s;
    logic        wb_done_s;
    logic        busy_s;
    logic [13:0] addr_s;
    logic [63:0] wdata_s;
    logic [63:0] line_s;
    logic        grant_wb_s;
    logic        grant_d_s;
    logic        grant_i_s;
`ifdef MEM_ARB_RR_EN
    logic        last_d_r;
    logic        last_d_s;
    logic        d_side_s;
`endif

    // Next-state and next-output decode; every output is held unless a transition changes it.
    always_comb begin
        next_state_s = state_r;
        re_s         = mem_re;
        we_s         = mem_we;
        addr_s       = mem_addr;
        wdata_s      = mem_wdata;
        line_s       = rd_line;
        i_vld_s      = 1'b0;
        d_vld_s      = 1'b0;
        wb_done_s    = 1'b0;
`ifdef MEM_ARB_RR_EN
        // The side not served last wins a collision; wb still beats fill inside D.
        last_d_s     = last_d_r;
        d_side_s     = (d_wb_req | d_req) & (~i_req | ~last_d_r);
        grant_wb_s   = d_side_s & d_wb_req;
        grant_d_s    = d_side_s & ~d_wb_req & d_req;
        grant_i_s    = ~d_side_s & i_req;
`else
        grant_wb_s   = d_wb_req;
        grant_d_s    = ~d_wb_req & d_req;
        grant_i_s    = ~d_wb_req & ~d_req & i_req;
`endif
        case (state_r)
            IDLE: begin
                if (grant_wb_s) begin
                    next_state_s = WB;
                    we_s         = 1'b1;
                    addr_s       = d_wb_addr;
                    wdata_s      = d_wb_data;
                end else if (grant_d_s) begin
                    next_state_s = D_FILL;
                    re_s         = 1'b1;
                    addr_s       = d_addr;
                end else if (grant_i_s) begin
                    next_state_s = I_FILL;
                    re_s         = 1'b1;
                    addr_s       = i_addr;
                end else begin
                    next_state_s = IDLE;
                end
`ifdef MEM_ARB_RR_EN
                if (grant_wb_s | grant_d_s) begin
                    last_d_s = 1'b1;
                end else if (grant_i_s) begin
                    last_d_s = 1'b0;
                end else begin
                    last_d_s = last_d_r;
                end
`endif
            end
            WB: begin
                if (mem_rdy) begin
                    next_state_s = DONE;
                    we_s         = 1'b0;
                    wb_done_s    = 1'b1;
                end else begin
                    next_state_s = WB;
                end
            end
            D_FILL: begin
                if (mem_rdy) begin
                    next_state_s = DONE;
                    re_s         = 1'b0;
                    line_s       = mem_rdata;
                    d_vld_s      = 1'b1;
                end else begin
                    next_state_s = D_FILL;
                end
            end
            I_FILL: begin
                if (mem_rdy) begin
                    next_state_s = DONE;
                    re_s         = 1'b0;
                    line_s       = mem_rdata;
                    i_vld_s      = 1'b1;
                end else begin
                    next_state_s = I_FILL;
                end
            end
            DONE: begin
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
                re_s         = 1'b0;
                we_s         = 1'b0;
            end
        endcase
        busy_s = (next_state_s != IDLE);
    end

    // State and registered outputs; reset abandons any in-flight transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 14'd0;
            mem_wdata <= 64'd0;
            rd_line   <= 64'd0;
            i_vld     <= 1'b0;
            d_vld     <= 1'b0;
            d_wb_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            mem_re    <= re_s;
            mem_we    <= we_s;
            mem_addr  <= addr_s;
            mem_wdata <= wdata_s;
            rd_line   <= line_s;
            i_vld     <= i_vld_s;
            d_vld     <= d_vld_s;
            d_wb_done <= wb_done_s;
            busy      <= busy_s;
        end
    end

`ifdef MEM_ARB_RR_EN
    // Last-grant flop; reset value favours the D side on the first collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_r <= 1'b0;
        end else begin
            last_d_r <= last_d_s;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected completions are queued at stimulus time and
// compared against a monitor that watches strobes and completion pulses.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req, d_req, d_wb_req;
    logic [13:0] i_addr, d_addr, d_wb_addr;
    logic [63:0] d_wb_data;
    logic        i_vld, d_vld, d_wb_done, mem_re, mem_we, busy, mem_rdy;
    logic [63:0] rd_line, mem_wdata, mem_rdata;
    logic [13:0] mem_addr;

    logic        auto_rdy = 1'b0;
    logic        stray_rdy = 1'b0;
    logic [63:0] auto_data = 64'd0;
    logic [63:0] stray_data = 64'd0;

    assign mem_rdy   = auto_rdy | stray_rdy;
    assign mem_rdata = stray_rdy ? stray_data : auto_data;

    typedef struct {
        int          kind;
        logic [13:0] addr;
        logic [63:0] data;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   pass_cnt = 0;
    int   chk_cnt = 0;
    int   lat = 4;
    int   pulse_cnt = 0;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr),
        .d_wb_req(d_wb_req), .d_wb_addr(d_wb_addr), .d_wb_data(d_wb_data),
        .i_vld(i_vld), .d_vld(d_vld), .d_wb_done(d_wb_done),
        .rd_line(rd_line), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_rdy(mem_rdy), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mem_data(input logic [13:0] a);
        if (a == 14'h0123) return 64'hDEADBEEF_CAFEF00D;
        return {16'hA5C3, 2'b00, a, 18'h0, a};
    endfunction

    function automatic void expect_txn(input int kind, input logic [13:0] a, input logic [63:0] d);
        sb_q.push_back(exp_t'{kind, a, d, lat});
    endfunction

    // Memory model: raise mem_rdy in the lat-th cycle of a strobe.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (rst_n && (mem_re || mem_we)) begin
                cnt++;
                auto_rdy  = (cnt == lat);
                auto_data = mem_data(mem_addr);
            end else begin
                cnt      = 0;
                auto_rdy = 1'b0;
            end
        end
    end

    // Monitor: track each strobe and compare every completion pulse against the scoreboard.
    initial begin
        logic [13:0] cur_addr;
        logic [63:0] cur_wdata;
        int          slen;
        bit          rdy_seen;
        int          kind;
        exp_t        e;
        slen = 0;
        rdy_seen = 1'b0;
        cur_addr = 14'd0;
        cur_wdata = 64'd0;
        forever begin
            @(negedge clk);
            #2;
            if (rdy_seen) check_eq("pulse_after_rdy", {63'd0, i_vld | d_vld | d_wb_done}, 64'd1);
            rdy_seen = 1'b0;
            if (mem_re || mem_we) begin
                if (slen == 0) begin
                    cur_addr  = mem_addr;
                    cur_wdata = mem_wdata;
                end else begin
                    check_eq("addr_stable", mem_addr, cur_addr);
                end
                slen++;
                check_eq("strobe_excl", mem_re & mem_we, 1'b0);
                check_eq("busy_in_xfer", busy, 1'b1);
                if (mem_rdy) rdy_seen = 1'b1;
            end
            if (i_vld || d_vld || d_wb_done) begin
                pulse_cnt++;
                check_eq("one_pulse", int'(i_vld) + int'(d_vld) + int'(d_wb_done), 64'd1);
                check_eq("busy_done", busy, 1'b1);
                check_eq("strobe_off_done", {mem_re, mem_we}, 2'b00);
                kind = d_wb_done ? 0 : (d_vld ? 1 : 2);
                check_eq("pulse_expected", sb_q.size() > 0, 1'b1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_eq("txn_kind", kind, e.kind);
                    check_eq("txn_addr", cur_addr, e.addr);
                    check_eq("txn_data", (kind == 0) ? cur_wdata : rd_line, e.data);
                    check_eq("strobe_len", slen, e.lat);
                end
            end
            if (!(mem_re || mem_we)) slen = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic serve(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (d_wb_done) d_wb_req = 1'b0;
            if (d_vld) d_req = 1'b0;
            if (i_vld) i_req = 1'b0;
            if (!(i_req || d_req || d_wb_req)) break;
        end
        check_eq("serve_timeout", {i_req, d_req, d_wb_req}, 3'b000);
        tick(2);
    endtask

    task automatic stray_pulse(input logic [63:0] data);
        stray_data = data;
        stray_rdy  = 1'b1;
        @(negedge clk);
        stray_rdy  = 1'b0;
    endtask

    initial begin
        logic [63:0] saved;
        int          pc;
        rst_n = 1'b1;
        {i_req, d_req, d_wb_req} = 3'b000;
        i_addr = 14'd0; d_addr = 14'd0; d_wb_addr = 14'd0; d_wb_data = 64'd0;
        #2 rst_n = 1'b0;
        tick(3);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_strobes", {mem_re, mem_we}, 2'b00);
        check_eq("rst_pulses", {i_vld, d_vld, d_wb_done}, 3'b000);
        check_eq("rst_addr", mem_addr, 14'd0);
        check_eq("rst_wdata", mem_wdata, 64'd0);
        check_eq("rst_line", rd_line, 64'd0);
        rst_n = 1'b1;
        tick(2);
        check_eq("idle_busy", busy, 1'b0);

        // I-fill alone with 4-cycle memory latency.
        lat = 4;
        i_addr = 14'h0123; i_req = 1'b1;
        expect_txn(2, 14'h0123, 64'hDEADBEEF_CAFEF00D);
        serve(50);
        check_eq("line_held", rd_line, 64'hDEADBEEF_CAFEF00D);

        // Writeback and fill together: writeback goes first.
        lat = 2;
        d_wb_addr = 14'h0040; d_wb_data = 64'h0123_4567_89AB_CDEF; d_addr = 14'h0080;
        d_wb_req = 1'b1; d_req = 1'b1;
        expect_txn(0, 14'h0040, 64'h0123_4567_89AB_CDEF);
        expect_txn(1, 14'h0080, mem_data(14'h0080));
        serve(80);

        // Stray mem_rdy while idle.
        saved = rd_line;
        pc = pulse_cnt;
        stray_pulse(64'hBAD0_BAD0_BAD0_BAD0);
        tick(3);
        check_eq("stray_busy", busy, 1'b0);
        check_eq("stray_line", rd_line, saved);
        check_eq("stray_pulses", pulse_cnt, pc);

        // Collisions between I and D sides, starting from reset.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2);
        lat = 3;
        i_addr = 14'h0300; d_addr = 14'h0280;
        i_req = 1'b1; d_req = 1'b1;
        expect_txn(1, 14'h0280, mem_data(14'h0280));
        expect_txn(2, 14'h0300, mem_data(14'h0300));
        serve(80);
        d_addr = 14'h0290; d_req = 1'b1;
        expect_txn(1, 14'h0290, mem_data(14'h0290));
        serve(50);
        i_addr = 14'h0310; d_addr = 14'h02A0;
        i_req = 1'b1; d_req = 1'b1;
`ifdef MEM_ARB_RR_EN
        expect_txn(2, 14'h0310, mem_data(14'h0310));
        expect_txn(1, 14'h02A0, mem_data(14'h02A0));
`else
        expect_txn(1, 14'h02A0, mem_data(14'h02A0));
        expect_txn(2, 14'h0310, mem_data(14'h0310));
`endif
        serve(80);

        // Reset two cycles into a fill abandons it.
        lat = 100;
        d_addr = 14'h0200; d_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (mem_re) break;
        end
        check_eq("fill_started", mem_re, 1'b1);
        tick(1);
        #3 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_re", mem_re, 1'b0);
        check_eq("mid_rst_busy", busy, 1'b0);
        check_eq("mid_rst_pulses", {i_vld, d_vld, d_wb_done}, 3'b000);
        check_eq("mid_rst_addr", mem_addr, 14'd0);
        check_eq("mid_rst_line", rd_line, 64'd0);
        d_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
        pc = pulse_cnt;
        tick(2);
        stray_pulse(64'h5555_AAAA_5555_AAAA);
        tick(4);
        check_eq("post_rst_pulses", pulse_cnt, pc);
        check_eq("post_rst_busy", busy, 1'b0);
        check_eq("post_rst_line", rd_line, 64'd0);

        check_eq("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have: i_req  in  1  I-cache line fill request, level, held until i_vld.
REQ-004 SHALL have: i_addr  in  14  I-cache line address.
REQ-005 SHALL have: d_req  in  1  D-cache line fill request, level, held until d_vld.
REQ-006 SHALL have: d_addr  in  14  D-cache fill line address.
REQ-007 SHALL have: d_wb_req  in  1  D-cache dirty-line writeback request, level, held until d_wb_done.
REQ-008 SHALL have: d_wb_addr  in  14  writeback line address.
REQ-009 SHALL have: d_wb_data  in  64  writeback line data.
REQ-010 SHALL have: i_vld / d_vld / d_wb_done  out  1 each  one-cycle completion pulses.
REQ-011 SHALL have: rd_line  out  64  fill data, shared by both sides, valid while i_vld or d_vld.
REQ-012 SHALL have: mem_re / mem_we  out  1 each  memory strobes, mutually exclusive.
REQ-013 SHALL have: mem_addr  out  14; mem_wdata  out  64; mem_rdata  in  64; mem_rdy  in  1  one-cycle memory completion.
REQ-014 SHALL have: busy  out  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, WB, D_FILL, I_FILL, DONE; all outputs registered.
REQ-016 SHALL sample requests only in IDLE; requests arriving in other states wait.
REQ-017 SHALL, in IDLE, select by priority d_wb_req > d_req > i_req (fixed-priority build).
REQ-018 SHALL, on selection at edge t, enter the grant state and drive the strobe, mem_addr (and mem_wdata for WB) from cycle t+1, held stable until mem_rdy.
REQ-019 SHALL, when mem_rdy is high in cycle n, drop the strobe, capture mem_rdata into rd_line (fills only), enter DONE in cycle n+1 and pulse the matching completion output in that cycle only.
REQ-020 SHALL return from DONE to IDLE unconditionally; minimum grant-to-grant spacing is one IDLE cycle.
REQ-021 SHALL require the served requester to deassert its request by the edge ending its completion pulse; the arbiter does not mask it afterwards.
REQ-022 SHALL ignore mem_rdy in IDLE and DONE; no pulse, no state change.
REQ-023 SHALL never assert mem_re and mem_we together, nor more than one completion pulse per cycle.
REQ-024 SHALL hold rd_line at its last captured value outside fill completion.
REQ-025 SHALL, when d_wb_req and d_req are both high, complete WB, pass through DONE and IDLE, then serve D_FILL, so a dirty victim is written before its replacement is read.
REQ-026 SHALL count memory latency with no internal timeout; the strobe remains held indefinitely until mem_rdy.

Reset
REQ-027 SHALL, on rst_n low at any time including mid-transaction, immediately force IDLE, drive all outputs (strobes, pulses, busy, mem_addr, mem_wdata, rd_line) to zero, and abandon the in-flight transaction.
REQ-028 SHALL, after rst_n release, take no grant before the first rising edge at which requests are sampled in IDLE.

Configuration
REQ-029 SHALL, with macro MEM_ARB_RR_EN defined, arbitrate between the D side (wb or fill) and the I side round-robin: a one-bit last-grant flop (reset to I) gives the side not last served priority when both request; wb still precedes fill within D.
REQ-030 SHALL, without MEM_ARB_RR_EN, use the fixed priority of REQ-017 and contain no last-grant state.

Verification
REQ-031 SHALL cover: i_req only, i_addr=0x0123, memory returns mem_rdy 4 cycles after mem_re, mem_rdata=64'hDEADBEEF_CAFEF00D -> mem_re high 4 cycles, i_vld pulses one cycle after mem_rdy with rd_line equal to that data.
REQ-032 SHALL cover: d_wb_req and d_req together (wb 0x0040, fill 0x0080) -> mem_we with addr 0x0040 first, d_wb_done, then mem_re with addr 0x0080, d_vld.
REQ-033 SHALL cover: i_req and d_req simultaneous in fixed build -> D served first; with MEM_ARB_RR_EN after reset -> D first, then on a repeated collision I first.
REQ-034 SHALL cover: rst_n asserted 2 cycles into a fill -> mem_re, busy, pulses low immediately; no completion pulse after release even if mem_rdy then arrives.
REQ-035 SHALL cover: stray mem_rdy in IDLE -> no pulse, busy stays 0, rd_line unchanged.
